// File: rtl/square_pkg.sv
// Shared definitions for the shift-add squarer: FSM state encoding and counter sizing.
// The optional SQUARE_EARLY_EXIT_EN macro is consumed in square.sv only.
package square_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions for sizing the bit counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/square_step.sv
// One combinational shift-add step: conditionally add the shifted multiplicand.
module square_step #(
    parameter int Width = 32
) (
    input  logic [2*Width-1:0] acc,
    input  logic [2*Width-1:0] mcand,
    input  logic               mbit,
    output logic [2*Width-1:0] acc_nxt
);

    always_comb begin
        acc_nxt = acc;
        if (mbit) begin
            acc_nxt = acc + mcand;
        end
    end

endmodule

// File: rtl/square.sv
// Sequential squarer y = x*x using one shift-add step per clock, four-phase req/fin handshake.
// Define SQUARE_EARLY_EXIT_EN to leave CALC once the remaining multiplier bits are all zero.
module square
    import square_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    output logic               fin,
    input  logic [Width-1:0]   x,
    output logic [2*Width-1:0] y
);

    localparam int CW = (clog2(Width) > 0) ? clog2(Width) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(Width - 1);

    state_t             state;
    logic [Width-1:0]   opnd;
    logic [2*Width-1:0] mcand;
    logic [2*Width-1:0] acc;
    logic [2*Width-1:0] acc_nxt;
    logic [CW-1:0]      cnt;
    logic               last;

    square_step #(.Width(Width)) u_step (
        .acc     (acc),
        .mcand   (mcand),
        .mbit    (opnd[0]),
        .acc_nxt (acc_nxt)
    );

    // last is true on the CALC edge that consumes the final meaningful multiplier bit.
`ifdef SQUARE_EARLY_EXIT_EN
    assign last = (cnt == CNT_LAST) || (opnd[Width-1:1] == '0);
`else
    assign last = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fin   <= 1'b0;
            y     <= '0;
            acc   <= '0;
            opnd  <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        opnd  <= x;
                        mcand <= {{Width{1'b0}}, x};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!req) begin
                        // Abort: y keeps the previous completed result.
                        state <= IDLE;
                    end else begin
                        acc   <= acc_nxt;
                        mcand <= mcand << 1;
                        opnd  <= opnd >> 1;
                        cnt   <= cnt + CW'(1);
                        if (last) begin
                            y     <= acc_nxt;
                            fin   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!req) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    fin   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
